// File: rtl/pattern_feeder_if.sv
// pattern_feeder request/response bus.
// master drives trocar; slave returns command_out, ack and patterns_issued.
interface pattern_feeder_if #(
  parameter int NUM_ROWS = 4
);
  logic [NUM_ROWS-1:0]   trocar;
  logic [4*NUM_ROWS-1:0] command_out;
  logic [NUM_ROWS-1:0]   ack;
  logic [15:0]           patterns_issued;

  modport master (
    output trocar,
    input  command_out,
    input  ack,
    input  patterns_issued
  );

  modport slave (
    input  trocar,
    output command_out,
    output ack,
    output patterns_issued
  );
endinterface

// File: rtl/pattern_feeder.sv
// Round-robin lane-pattern server: LFSR or chart ROM source, difficulty mask.
// Ports: CLOCK_25, reset (sync, high), enable, mode_chart, difficulty, bus (slave).
module pattern_feeder #(
  parameter int          NUM_ROWS = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_chart,
  input  logic [1:0] difficulty,
  pattern_feeder_if.slave bus
);

  localparam int PW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [NUM_ROWS-1:0]   pend_q, pend_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [3:0]            idx_q, idx_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [4*NUM_ROWS-1:0] cmd_q, cmd_d;
  logic [NUM_ROWS-1:0]   ack_q, ack_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [PW-1:0] sel;
  logic          found;
  logic          serve;
  logic [15:0]   lfsr_nx;
  logic [3:0]    raw_lfsr;
  logic [3:0]    raw_chart;
  logic [3:0]    raw;
  logic [3:0]    pat;

  // First pending row at or after rr_q, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      j = (int'(rr_q) + k) % NUM_ROWS;
      if (!found && pend_q[j]) begin
        found = 1'b1;
        sel   = PW'(j);
      end
    end
  end

  assign serve = enable & found;

  assign lfsr_nx = {1'b0, lfsr_q[15:1]}
                 ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // An all-zero LFSR nibble would be a dead row; pick one lane instead.
  assign raw_lfsr = (lfsr_nx[3:0] == 4'd0)
                  ? (4'b0001 << lfsr_nx[5:4])
                  : lfsr_nx[3:0];

  always_comb begin
    raw_chart = 4'd0;
    unique case (idx_q)
      4'd0:  raw_chart = 4'd1;
      4'd1:  raw_chart = 4'd2;
      4'd2:  raw_chart = 4'd4;
      4'd3:  raw_chart = 4'd8;
      4'd4:  raw_chart = 4'd3;
      4'd5:  raw_chart = 4'd6;
      4'd6:  raw_chart = 4'd12;
      4'd7:  raw_chart = 4'd9;
      4'd8:  raw_chart = 4'd5;
      4'd9:  raw_chart = 4'd10;
      4'd10: raw_chart = 4'd1;
      4'd11: raw_chart = 4'd8;
      4'd12: raw_chart = 4'd2;
      4'd13: raw_chart = 4'd4;
      4'd14: raw_chart = 4'd15;
      4'd15: raw_chart = 4'd0;
      default: raw_chart = 4'd0;
    endcase
  end

  assign raw = mode_chart ? raw_chart : raw_lfsr;

  // Keep the lowest difficulty+1 set lanes.
  always_comb begin
    logic [2:0] n;
    pat = 4'd0;
    n   = 3'd0;
    for (int b = 0; b < 4; b++) begin
      if (raw[b] && (n <= {1'b0, difficulty})) begin
        pat[b] = 1'b1;
        n      = n + 3'd1;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    rr_d   = rr_q;
    idx_d  = idx_q;
    lfsr_d = lfsr_q;
    cmd_d  = cmd_q;
    ack_d  = '0;
    cnt_d  = cnt_q;
    if (serve) begin
      pend_d[sel]          = 1'b0;
      cmd_d[4*sel +: 4]    = pat;
      ack_d[sel]           = 1'b1;
      cnt_d                = cnt_q + 16'd1;
      rr_d = (int'(sel) == NUM_ROWS - 1) ? '0 : sel + PW'(1);
      if (mode_chart) idx_d  = idx_q + 4'd1;
      else            lfsr_d = lfsr_nx;
    end
    // A fresh request on the serving edge re-arms the row.
    pend_d = pend_d | bus.trocar;
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      pend_q <= '0;
      rr_q   <= '0;
      idx_q  <= '0;
      lfsr_q <= SEED;
      ack_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NUM_ROWS; i++)
        cmd_q[4*i +: 4] <= 4'b0001 << (i % 4);
    end else begin
      pend_q <= pend_d;
      rr_q   <= rr_d;
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
      ack_q  <= ack_d;
      cnt_q  <= cnt_d;
      cmd_q  <= cmd_d;
    end
  end

  assign bus.command_out     = cmd_q;
  assign bus.ack             = ack_q;
  assign bus.patterns_issued = cnt_q;

endmodule
